// File: rtl/raster_to_block.sv
// Raster-to-8x8-block reorder for one colour plane, ping-pong 8-line stripe buffers.
// Latency: stripe's last sample at edge N -> first out_valid after edge N+1.
// Backpressure: out_ready stalls readout only; input never stalls, overflow drops input until next in_sof.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_data/in_sof      raster sample stream (in_sof marks frame start)
//   out_valid/out_ready          output beat handshake
//   out_row                      8 samples of a block row, sample c at [8c+7:8c]
//   out_sob/out_eob/out_eof      block-start, block-end, frame-end flags
//   overflow                     sticky: input dropped because the write bank was full
module raster_to_block #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_row,
  output logic        out_sob,
  output logic        out_eob,
  output logic        out_eof,
  output logic        overflow
);

  localparam int BW  = WIDTH / 8;
  localparam int NS  = HEIGHT / 8;
  localparam int CW  = $clog2(WIDTH);
  localparam int BCW = (BW > 1) ? $clog2(BW) : 1;
  localparam int SW  = (NS > 1) ? $clog2(NS) : 1;
  localparam int AW  = $clog2(2 * WIDTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  // Bank k occupies words k*WIDTH .. k*WIDTH+WIDTH-1; word = line*BW + block column.
  function automatic logic [AW-1:0] f_addr(input logic bank, input int r, input int b);
    int a;
    a = (bank ? WIDTH : 0) + r * BW + b;
    return a[AW-1:0];
  endfunction

  logic [63:0]    r_mem [0:2*WIDTH-1];

  // Write side state
  logic [CW-1:0]  r_col;
  logic [2:0]     r_line;
  logic [SW-1:0]  r_stripe;
  logic           r_wr_bank;
  logic [55:0]    r_asm;
  logic [1:0]     r_full;
  logic [1:0]     r_last;
  logic           r_overflow;

  // Read side state
  state_t         r_state;
  logic           r_rd_bank;
  logic [BCW-1:0] r_rb;
  logic [2:0]     r_rr;

  // in_sof restarts the frame on the very sample that carries it.
  logic [CW-1:0]  w_col;
  logic [2:0]     w_line;
  logic [SW-1:0]  w_stripe;
  logic           w_accept;
  logic           w_bank_full;
  logic           w_wr_en;
  logic [AW-1:0]  w_waddr;

  assign w_col       = in_sof ? '0 : r_col;
  assign w_line      = in_sof ? '0 : r_line;
  assign w_stripe    = in_sof ? '0 : r_stripe;
  assign w_accept    = in_valid && (in_sof || !r_overflow);
  assign w_bank_full = r_full[r_wr_bank];
  assign w_wr_en     = w_accept && !w_bank_full && (w_col[2:0] == 3'd7);
  assign w_waddr     = f_addr(r_wr_bank, int'(w_line), int'(w_col) / 8);
  assign overflow    = r_overflow;

  // Read-side next-beat selection
  logic           w_ld;
  logic           w_ld_bank;
  logic [2:0]     w_ld_r;
  logic [BCW-1:0] w_ld_b;
  logic           w_rd_done;
  logic [AW-1:0]  w_raddr;

  always_comb begin
    w_ld      = 1'b0;
    w_ld_bank = r_rd_bank;
    w_ld_r    = 3'd0;
    w_ld_b    = '0;
    w_rd_done = 1'b0;
    case (r_state)
      S_IDLE: w_ld = r_full[r_rd_bank];
      S_SEND: begin
        if (out_ready) begin
          if (r_rr == 3'd7 && r_rb == BCW'(BW - 1)) begin
            // Chain straight into the other bank when it is already full: no idle beat.
            w_rd_done = 1'b1;
            w_ld_bank = ~r_rd_bank;
            w_ld      = r_full[~r_rd_bank];
          end else begin
            w_ld = 1'b1;
            if (r_rr == 3'd7) begin
              w_ld_b = r_rb + BCW'(1);
            end else begin
              w_ld_r = r_rr + 3'd1;
              w_ld_b = r_rb;
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign w_raddr = f_addr(w_ld_bank, int'(w_ld_r), int'(w_ld_b));

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_waddr] <= {in_data, r_asm};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_line     <= '0;
      r_stripe   <= '0;
      r_wr_bank  <= 1'b0;
      r_asm      <= '0;
      r_full     <= '0;
      r_last     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        if (in_sof) begin
          r_col      <= '0;
          r_line     <= '0;
          r_stripe   <= '0;
          r_overflow <= 1'b0;
        end
        if (w_bank_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_asm <= {in_data, r_asm[55:8]};
          if (w_col == CW'(WIDTH - 1)) begin
            r_col <= '0;
            if (w_line == 3'd7) begin
              r_line               <= '0;
              r_full[r_wr_bank]    <= 1'b1;
              r_last[r_wr_bank]    <= (w_stripe == SW'(NS - 1));
              r_wr_bank            <= ~r_wr_bank;
              r_stripe             <= (w_stripe == SW'(NS - 1)) ? '0 : w_stripe + SW'(1);
            end else begin
              r_line <= w_line + 3'd1;
            end
          end else begin
            r_col <= w_col + CW'(1);
          end
        end
      end
      // The read bank is full while being drained, so the write side never targets it here.
      if (w_rd_done) r_full[r_rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_bank <= 1'b0;
      r_rb      <= '0;
      r_rr      <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      if (w_ld) begin
        r_state   <= S_SEND;
        r_rr      <= w_ld_r;
        r_rb      <= w_ld_b;
        out_valid <= 1'b1;
        out_row   <= r_mem[w_raddr];
        out_sob   <= (w_ld_r == 3'd0);
        out_eob   <= (w_ld_r == 3'd7);
        out_eof   <= (w_ld_r == 3'd7) && (w_ld_b == BCW'(BW - 1)) && r_last[w_ld_bank];
      end else if (w_rd_done) begin
        r_state   <= S_IDLE;
        out_valid <= 1'b0;
        out_sob   <= 1'b0;
        out_eob   <= 1'b0;
        out_eof   <= 1'b0;
      end
      if (w_rd_done) r_rd_bank <= ~r_rd_bank;
    end
  end

endmodule

// File: tb/tb_raster_to_block.sv
module tb_raster_to_block;
  localparam int W  = 24;
  localparam int H  = 16;
  localparam int NB = W / 8;
  localparam int NS = H / 8;

  logic        clk, rst;
  logic        in_valid, in_sof;
  logic [7:0]  in_data;
  logic        out_valid, out_ready;
  logic [63:0] out_row;
  logic        out_sob, out_eob, out_eof, overflow;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;

  // Expected beat: {row, sob, eob, eof}
  logic [66:0] sb[$];
  logic [7:0]  pix [0:H-1][0:W-1];

  logic        prev_stall = 1'b0;
  logic [66:0] prev_beat  = '0;

  raster_to_block #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_sob(out_sob), .out_eob(out_eob), .out_eof(out_eof),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Monitor: samples on the falling edge; a beat is taken at the next rising edge.
  always @(negedge clk) begin
    logic [66:0] act, exp_b;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      act = {out_row, out_sob, out_eob, out_eof};
      if (prev_stall) begin
        checks++;
        if (!out_valid || act !== prev_beat) begin
          failures++;
          $display("FAIL stall_hold valid=%0b actual=%h required=%h", out_valid, act, prev_beat);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        beats++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none", act);
        end else begin
          exp_b = sb.pop_front();
          if (act !== exp_b) begin
            failures++;
            $display("FAIL beat%0d actual=%h required=%h", beats - 1, act, exp_b);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = act;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic sof);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Reference: block b, row r of stripe s is line s*8+r, columns b*8..b*8+7.
  task automatic push_stripe(input int s);
    logic [63:0] row;
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) row[8*c +: 8] = pix[s*8+r][b*8+c];
        sb.push_back({row, (r == 0), (r == 7), (r == 7) && (b == NB - 1) && (s == NS - 1)});
      end
    end
  endtask

  // dmode: 0 continuous, 1 one-in-three, 2 random gaps
  task automatic send_frame(input int dmode, input bit pattern, input bit push,
                            input int nlines, input bit chk_lat);
    logic [7:0] d;
    bit lat_pending;
    lat_pending = 1'b0;
    for (int line = 0; line < nlines; line++) begin
      for (int col = 0; col < W; col++) begin
        d = pattern ? 8'((line * W + col) & 255) : 8'($urandom_range(0, 255));
        pix[line][col] = d;
        send(d, (line == 0 && col == 0));
        if (line == 0 && col == 0) chk("ovf_clear_on_sof", overflow, 0);
        if (lat_pending) begin
          chk("lat_valid_edge_n1", out_valid, 1);
          lat_pending = 1'b0;
        end
        if (col == W - 1 && line % 8 == 7) begin
          if (push) push_stripe(line / 8);
          if (chk_lat && line == 7) begin
            chk("lat_valid_edge_n", out_valid, 0);
            lat_pending = 1'b1;
          end
        end
        if (dmode == 1) repeat (2) tick();
        else if (dmode == 2) repeat ($urandom_range(0, 2)) tick();
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4000 && sb.size() != 0; i++) tick();
    chk({name, "_drained"}, sb.size(), 0);
    repeat (3) tick();
    chk({name, "_idle"}, out_valid, 0);
  endtask

  task automatic ready_ctl();
    int base;
    base = beats;
    for (int i = 0; i < 4000 && beats < base + 5; i++) tick();
    chk("bp_reach_beat5", (beats >= base + 5), 1);
    out_ready = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 6000 && beats < base + 48; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_flags", {out_sob, out_eob, out_eof}, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Continuous pattern frame, with first-output latency check
    send_frame(0, 1'b1, 1'b1, H, 1'b1);
    wait_drain("s1");

    // Same pattern, one sample every third cycle
    send_frame(1, 1'b1, 1'b1, H, 1'b0);
    wait_drain("s2");

    // Random data and gaps, backpressure stall then toggling ready
    fork
      send_frame(2, 1'b0, 1'b1, H, 1'b0);
      ready_ctl();
    join
    wait_drain("s3");

    // Overflow: both banks full while output is blocked
    out_ready = 1'b0;
    send_frame(0, 1'b0, 1'b1, H, 1'b0);
    send(8'hA5, 1'b1);
    chk("ovf_set", overflow, 1);
    repeat (20) send(8'($urandom_range(0, 255)), 1'b0);
    chk("ovf_sticky", overflow, 1);
    out_ready = 1'b1;
    wait_drain("s4");
    send_frame(0, 1'b0, 1'b1, H, 1'b0);
    wait_drain("s4b");

    // in_sof after 3 lines discards the partial stripe
    send_frame(0, 1'b0, 1'b0, 3, 1'b0);
    send_frame(2, 1'b0, 1'b1, H, 1'b0);
    wait_drain("s5");

    // Reset during readout with overflow active
    out_ready = 1'b0;
    send_frame(0, 1'b0, 1'b1, H, 1'b0);
    send(8'h3C, 1'b1);
    chk("rst_case_ovf_set", overflow, 1);
    base = beats;
    out_ready = 1'b1;
    for (int i = 0; i < 4000 && beats < base + 20; i++) tick();
    chk("rst_reach_beat20", (beats >= base + 20), 1);
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_overflow", overflow, 0);
    rst = 1'b0;
    sb.delete();
    repeat (2) tick();
    chk("postrst_quiet", out_valid, 0);
    send_frame(0, 1'b1, 1'b1, H, 1'b1);
    wait_drain("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
